// File: rtl/othello_solver.sv
// Exact Othello endgame solver: iterative negamax alpha-beta over an on-chip stack,
// with valid/ready handshakes on the problem and result sides.
module othello_solver #(
  parameter int STACK_DEPTH = 16,
  parameter int FLIP_LAT    = 4,
  parameter int NODE_W      = 32
) (
  input  logic              iCLOCK,
  input  logic              iRESET_N,
  input  logic              iValid,
  output logic              oReady,
  input  logic [63:0]       iPlayer,
  input  logic [63:0]       iOpponent,
  input  logic [7:0]        iAlpha,
  input  logic [7:0]        iBeta,
  output logic              oValid,
  input  logic              iReady,
  output logic [7:0]        oScore,
  output logic [NODE_W-1:0] oNodes,
  output logic              oOverflow
);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = $clog2(FLIP_LAT + 1);
  localparam logic signed [7:0] NEG_INF = -8'sd64;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_FLIP   = 3'd3;
  localparam logic [2:0] S_PUSH   = 3'd4;
  localparam logic [2:0] S_POP    = 3'd5;
  localparam logic [2:0] S_COMMIT = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  // Square encoding in {x,y}: 10 player, 01 opponent, 11 empty, 00 empty already tried.
  logic [63:0]       stk_x     [STACK_DEPTH];
  logic [63:0]       stk_y     [STACK_DEPTH];
  logic signed [7:0] stk_res   [STACK_DEPTH];
  logic signed [7:0] stk_alpha [STACK_DEPTH];
  logic signed [7:0] stk_beta  [STACK_DEPTH];
  logic              stk_pass  [STACK_DEPTH];
  logic              stk_prev  [STACK_DEPTH];

  logic [2:0]        state;
  logic              phase;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  fcnt;
  logic [63:0]       cur_x, cur_y, cur_p, cur_o, cur_rem;
  logic signed [7:0] cur_res, cur_alpha, cur_beta;
  logic              cur_pass, cur_prev;
  logic signed [7:0] v_term, v_r, ret_r, pop_r, neg_ret;
  logic [5:0]        low_pos, low_pos_c;
  logic [63:0]       low_bit, flip_res;
  logic [63:0]       flip_pipe [FLIP_LAT];

  function automatic logic [63:0] flip_fn(input logic [63:0] p, input logic [63:0] o,
                                          input logic [5:0] pos);
    logic [63:0] res, run;
    logic        open;
    int          r, c, dr, dc;
    res = '0;
    for (int unsigned d = 0; d < 8; d++) begin
      case (d)
        0: begin dr = -1; dc = -1; end
        1: begin dr = -1; dc =  0; end
        2: begin dr = -1; dc =  1; end
        3: begin dr =  0; dc = -1; end
        4: begin dr =  0; dc =  1; end
        5: begin dr =  1; dc = -1; end
        6: begin dr =  1; dc =  0; end
        default: begin dr = 1; dc = 1; end
      endcase
      run  = '0;
      open = 1'b1;
      r    = int'(pos[5:3]);
      c    = int'(pos[2:0]);
      for (int unsigned s = 0; s < 7; s++) begin
        r = r + dr;
        c = c + dc;
        if (open) begin
          if (r < 0 || r > 7 || c < 0 || c > 7) open = 1'b0;
          else if (o[6'(r * 8 + c)]) run[6'(r * 8 + c)] = 1'b1;
          else begin
            if (p[6'(r * 8 + c)] && run != '0) res = res | run;
            open = 1'b0;
          end
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    low_pos_c = '0;
    for (int unsigned i = 0; i < 64; i++)
      if (cur_rem[63 - i]) low_pos_c = 6'(63 - i);
  end

  assign low_bit  = 64'd1 << low_pos;
  assign flip_res = flip_pipe[FLIP_LAT-1];
  assign pop_r    = cur_prev ? -v_r : v_r;
  assign neg_ret  = -ret_r;
  assign oReady   = (state == S_IDLE);

  always_ff @(posedge iCLOCK) begin
    if (!iRESET_N) begin
      state     <= S_IDLE;
      phase     <= 1'b0;
      idx       <= '0;
      fcnt      <= '0;
      oValid    <= 1'b0;
      oScore    <= '0;
      oNodes    <= '0;
      oOverflow <= 1'b0;
    end else begin
      for (int unsigned k = 1; k < FLIP_LAT; k++) flip_pipe[k] <= flip_pipe[k-1];
      case (state)
        S_IDLE: if (iValid) begin
          stk_x[0]     <= ~iOpponent;
          stk_y[0]     <= ~iPlayer;
          stk_res[0]   <= NEG_INF;
          stk_alpha[0] <= iAlpha;
          stk_beta[0]  <= iBeta;
          stk_pass[0]  <= 1'b1;
          stk_prev[0]  <= 1'b0;
          idx          <= '0;
          oNodes       <= NODE_W'(1);
          oOverflow    <= 1'b0;
          phase        <= 1'b0;
          state        <= S_READ;
        end
        S_READ: begin
          if (!phase) begin
            cur_x     <= stk_x[idx];
            cur_y     <= stk_y[idx];
            cur_res   <= stk_res[idx];
            cur_alpha <= stk_alpha[idx];
            cur_beta  <= stk_beta[idx];
            cur_pass  <= stk_pass[idx];
            cur_prev  <= stk_prev[idx];
          end else begin
            cur_p   <= cur_x & ~cur_y;
            cur_o   <= ~cur_x & cur_y;
            cur_rem <= cur_x & cur_y;
            state   <= S_CHECK;
          end
          phase <= ~phase;
        end
        S_CHECK: begin
          if (!phase) begin
            v_term  <= 8'($countones(cur_p) - $countones(cur_o));
            low_pos <= low_pos_c;
          end else if (cur_rem == '0 && cur_pass && cur_prev) begin
            v_r   <= v_term;
            state <= S_POP;
          end else if (cur_rem == '0 && cur_pass) begin
            // No move found: the same slot becomes the opponent's pass position.
            stk_x[idx]     <= ~cur_p;
            stk_y[idx]     <= ~cur_o;
            stk_res[idx]   <= NEG_INF;
            stk_alpha[idx] <= -cur_beta;
            stk_beta[idx]  <= -cur_alpha;
            stk_pass[idx]  <= 1'b1;
            stk_prev[idx]  <= 1'b1;
            if (oNodes != '1) oNodes <= oNodes + 1'b1;
            state <= S_READ;
          end else if (cur_rem == '0 || cur_alpha >= cur_beta) begin
            v_r   <= cur_res;
            state <= S_POP;
          end else begin
            stk_x[idx]   <= cur_x & ~low_bit;
            stk_y[idx]   <= cur_y & ~low_bit;
            flip_pipe[0] <= flip_fn(cur_p, cur_o, low_pos);
            fcnt         <= '0;
            state        <= S_FLIP;
          end
          phase <= ~phase;
        end
        S_FLIP: begin
          fcnt <= fcnt + 1'b1;
          if (fcnt == CNT_W'(FLIP_LAT - 1)) state <= (flip_res == '0) ? S_READ : S_PUSH;
        end
        S_PUSH: begin
          if (idx == IDX_W'(STACK_DEPTH - 1)) begin
            oOverflow <= 1'b1;
            oScore    <= '0;
            oValid    <= 1'b1;
            state     <= S_DONE;
          end else begin
            stk_pass[idx]    <= 1'b0;
            stk_x[idx+1]     <= ~((cur_p ^ flip_res) | low_bit);
            stk_y[idx+1]     <= ~(cur_o ^ flip_res);
            stk_res[idx+1]   <= NEG_INF;
            stk_alpha[idx+1] <= -cur_beta;
            stk_beta[idx+1]  <= -cur_alpha;
            stk_pass[idx+1]  <= 1'b1;
            stk_prev[idx+1]  <= 1'b0;
            idx              <= idx + 1'b1;
            if (oNodes != '1) oNodes <= oNodes + 1'b1;
            state <= S_READ;
          end
        end
        S_POP: begin
          if (idx == '0) begin
            oScore <= pop_r;
            oValid <= 1'b1;
            state  <= S_DONE;
          end else begin
            ret_r <= pop_r;
            idx   <= idx - 1'b1;
            state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          if (neg_ret > stk_res[idx])   stk_res[idx]   <= neg_ret;
          if (neg_ret > stk_alpha[idx]) stk_alpha[idx] <= neg_ret;
          state <= S_READ;
        end
        default: if (iReady) begin
          oValid <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end
endmodule
